// File: rtl/gate_selftest_seq.sv
// Built-in self-test sequencer for a 2-input bitwise gate: walks the four
// {a,b} vectors, samples the gate after SETTLE cycles and scores it against a truth table.
module gate_selftest_seq #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       truthTable,
  output logic [WIDTH-1:0] dutA,
  output logic [WIDTH-1:0] dutB,
  input  logic [WIDTH-1:0] dutOut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       failCount,
  output logic [1:0]       firstFailIdx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CHECK,
    S_DONE
  } state_t;

  // Out-of-range SETTLE values are clamped into 1..255 so the counter never overruns.
  localparam int         SETTLE_CLAMP = (SETTLE < 1) ? 1 : ((SETTLE > 255) ? 255 : SETTLE);
  localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CLAMP - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [7:0] r_cnt;
  logic [2:0] r_fail_cnt;
  logic [1:0] r_first_idx;
  logic [3:0] r_table;

  state_t     w_state_next;
  logic [1:0] w_idx_next;
  logic [7:0] w_cnt_next;
  logic [2:0] w_fail_cnt_next;
  logic [1:0] w_first_idx_next;
  logic [3:0] w_table_next;
  logic       w_vec_ok;
  logic       w_busy;

  // Case equality so any X/Z bit on the gate output scores as a failure.
  assign w_vec_ok = (dutOut === {WIDTH{r_table[r_idx]}});

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_cnt       <= 8'd0;
      r_fail_cnt  <= 3'd0;
      r_first_idx <= 2'd0;
      r_table     <= 4'd0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_cnt       <= w_cnt_next;
      r_fail_cnt  <= w_fail_cnt_next;
      r_first_idx <= w_first_idx_next;
      r_table     <= w_table_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_cnt_next       = r_cnt;
    w_fail_cnt_next  = r_fail_cnt;
    w_first_idx_next = r_first_idx;
    w_table_next     = r_table;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_table_next     = truthTable;
          w_fail_cnt_next  = 3'd0;
          w_first_idx_next = 2'd0;
          w_idx_next       = 2'd0;
          w_cnt_next       = 8'd0;
          w_state_next     = S_APPLY;
        end
      end

      S_APPLY: begin
        if (abort) begin
          w_state_next     = S_IDLE;
          w_fail_cnt_next  = 3'd0;
          w_first_idx_next = 2'd0;
          w_idx_next       = 2'd0;
          w_cnt_next       = 8'd0;
        end else if (r_cnt == SETTLE_LAST) begin
          w_cnt_next   = 8'd0;
          w_state_next = S_CHECK;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end

      S_CHECK: begin
        // Abort discards the pending score update for this vector.
        if (abort) begin
          w_state_next     = S_IDLE;
          w_fail_cnt_next  = 3'd0;
          w_first_idx_next = 2'd0;
          w_idx_next       = 2'd0;
          w_cnt_next       = 8'd0;
        end else begin
          if (!w_vec_ok) begin
            w_fail_cnt_next = r_fail_cnt + 3'd1;
            if (r_fail_cnt == 3'd0) begin
              w_first_idx_next = r_idx;
            end
          end
          if (r_idx == 2'd3) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_idx + 2'd1;
            w_state_next = S_APPLY;
          end
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_busy       = (r_state == S_APPLY) || (r_state == S_CHECK);
    busy         = w_busy;
    done         = (r_state == S_DONE);
    pass         = (r_state == S_DONE) && (r_fail_cnt == 3'd0);
    dutA         = '0;
    dutB         = '0;
    failCount    = r_fail_cnt;
    firstFailIdx = r_first_idx;
    if (w_busy) begin
      dutA = {WIDTH{r_idx[1]}};
      dutB = {WIDTH{r_idx[0]}};
    end
  end

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: two instances (1-bit/SETTLE=1 and 16-bit/SETTLE=3) with a
// behavioural gate, a cycle-level reference model and directed scenarios.
module tb_gate_selftest_seq;

  logic             clk = 1'b0;
  logic             resetN;
  logic [1:0]       start_s;
  logic [1:0]       abort_s;
  logic [1:0][3:0]  tab_s;
  int               fault_s [2];

  logic [1:0][15:0] a_s;
  logic [1:0][15:0] b_s;
  logic [1:0]       busy_s;
  logic [1:0]       done_s;
  logic [1:0]       pass_s;
  logic [1:0][2:0]  fc_s;
  logic [1:0][1:0]  ff_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;
  int seq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Whether the behavioural gate (fault mode f) disagrees with table entry v.
  function automatic bit vec_fails(input int w, input int v, input int f, input logic [3:0] tab);
    logic [15:0] mask;
    logic [15:0] word;
    logic [15:0] want;
    mask = (w == 16) ? 16'hFFFF : 16'h0001;
    word = (v != 0) ? 16'hFFFF : 16'h0000;
    if (f == 1) word = 16'h0000;
    if (f == 2 && v == 2) word = word ^ 16'h0080;
    want = tab[v] ? 16'hFFFF : 16'h0000;
    return ((word ^ want) & mask) != 16'h0000;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int W = (gi == 0) ? 1 : 16;
    localparam int S = (gi == 0) ? 1 : 3;
    localparam logic [15:0] MASK = (W == 16) ? 16'hFFFF : 16'h0001;

    logic [W-1:0] l_a, l_b, l_out;
    logic         l_busy, l_done, l_pass;
    logic [2:0]   l_fc;
    logic [1:0]   l_ff;

    gate_selftest_seq #(.WIDTH(W), .SETTLE(S)) dut (
      .clk          (clk),
      .resetN       (resetN),
      .start        (start_s[gi]),
      .abort        (abort_s[gi]),
      .truthTable   (tab_s[gi]),
      .dutA         (l_a),
      .dutB         (l_b),
      .dutOut       (l_out),
      .busy         (l_busy),
      .done         (l_done),
      .pass         (l_pass),
      .failCount    (l_fc),
      .firstFailIdx (l_ff)
    );

    always_comb begin
      l_out = l_a | l_b;
      if (fault_s[gi] == 1) l_out = '0;
      else if (fault_s[gi] == 2 && l_a[0] && !l_b[0]) l_out = l_out ^ W'(16'h0080);
    end

    assign a_s[gi]    = 16'(l_a);
    assign b_s[gi]    = 16'(l_b);
    assign busy_s[gi] = l_busy;
    assign done_s[gi] = l_done;
    assign pass_s[gi] = l_pass;
    assign fc_s[gi]   = l_fc;
    assign ff_s[gi]   = l_ff;

    // Reference model: elapsed cycles since start decide vector and phase.
    logic       m_busy, m_done;
    int         m_e, m_fc, m_ff;
    logic [3:0] m_tab;

    always @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_e <= 0; m_fc <= 0; m_ff <= 0; m_tab <= 4'd0;
      end else if (!m_busy) begin
        if (start_s[gi]) begin
          m_busy <= 1'b1; m_done <= 1'b0; m_e <= 0; m_fc <= 0; m_ff <= 0;
          m_tab  <= tab_s[gi];
        end
      end else if (abort_s[gi]) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_fc <= 0; m_ff <= 0;
      end else begin
        if ((m_e % (S + 1)) == S) begin
          if (vec_fails(W, m_e / (S + 1), fault_s[gi], m_tab)) begin
            m_fc <= m_fc + 1;
            if (m_fc == 0) m_ff <= m_e / (S + 1);
          end
          if ((m_e / (S + 1)) == 3) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end
        m_e <= m_e + 1;
      end
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d_busy", gi), 32'(busy_s[gi]), 32'(m_busy));
      chk($sformatf("g%0d_done", gi), 32'(done_s[gi]), 32'(m_done));
      chk($sformatf("g%0d_pass", gi), 32'(pass_s[gi]), 32'(m_done && m_fc == 0));
      chk($sformatf("g%0d_fc", gi), 32'(fc_s[gi]), 32'(m_fc));
      chk($sformatf("g%0d_ff", gi), 32'(ff_s[gi]), 32'(m_ff));
      chk($sformatf("g%0d_a", gi), 32'(a_s[gi]),
          32'((m_busy && (((m_e / (S + 1)) >> 1) & 1) != 0) ? MASK : 16'h0));
      chk($sformatf("g%0d_b", gi), 32'(b_s[gi]),
          32'((m_busy && ((m_e / (S + 1)) & 1) != 0) ? MASK : 16'h0));
    end
  end

  task automatic start_edge(input int k);
    @(negedge clk); #1 start_s[k] = 1'b1;
    @(posedge clk); #1 t0 = cyc;
    seq.delete();
    seq.push_back({30'd0, a_s[k][0], b_s[k][0]});
    @(negedge clk); #1 start_s[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int el);
    while (!done_s[k] && (cyc - t0) < 200) begin
      @(posedge clk); #1;
      if (busy_s[k]) seq.push_back({30'd0, a_s[k][0], b_s[k][0]});
    end
    el = cyc - t0;
  endtask

  initial begin
    int el;
    resetN  = 1'b1;
    start_s = 2'b00;
    abort_s = 2'b00;
    tab_s   = {4'b1110, 4'b1110};
    fault_s[0] = 0;
    fault_s[1] = 0;
    #2 resetN = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_done", 32'(done_s[0]), 32'd0);
    chk("rst_fc", 32'(fc_s[1]), 32'd0);
    chk("rst_a", 32'(a_s[1]), 32'd0);
    #1 resetN = 1'b1;

    // Correct OR gate: clean pass, vector order 00,01,10,11.
    start_edge(0);
    wait_done(0, el);
    $display("run1 or: elapsed=%0d pass=%0d fc=%0d ff=%0d", el, pass_s[0], fc_s[0], ff_s[0]);
    chk("t1_lat", 32'(el), 32'd8);
    chk("t1_busylen", 32'(seq.size()), 32'd8);
    chk("t1_v0", 32'(seq[0]), 32'd0);
    chk("t1_v1", 32'(seq[2]), 32'd1);
    chk("t1_v2", 32'(seq[4]), 32'd2);
    chk("t1_v3", 32'(seq[6]), 32'd3);
    chk("t1_pass", 32'(pass_s[0]), 32'd1);
    chk("t1_fc", 32'(fc_s[0]), 32'd0);
    chk("t1_ff", 32'(ff_s[0]), 32'd0);

    // Output stuck at 0.
    fault_s[0] = 1;
    start_edge(0);
    wait_done(0, el);
    $display("run2 stuck0: elapsed=%0d pass=%0d fc=%0d ff=%0d", el, pass_s[0], fc_s[0], ff_s[0]);
    chk("t2_lat", 32'(el), 32'd8);
    chk("t2_pass", 32'(pass_s[0]), 32'd0);
    chk("t2_fc", 32'(fc_s[0]), 32'd3);
    chk("t2_ff", 32'(ff_s[0]), 32'd1);

    // Start re-pulsed mid-run is ignored; start from DONE repeats the run.
    fault_s[0] = 0;
    start_edge(0);
    @(posedge clk); #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    wait_done(0, el);
    $display("run3 repulse: elapsed=%0d pass=%0d", el, pass_s[0]);
    chk("t4_lat", 32'(el), 32'd8);
    chk("t4_pass", 32'(pass_s[0]), 32'd1);
    start_edge(0);
    chk("t4_done_clr", 32'(done_s[0]), 32'd0);
    wait_done(0, el);
    $display("run4 restart: elapsed=%0d pass=%0d", el, pass_s[0]);
    chk("t4_lat2", 32'(el), 32'd8);
    chk("t4_pass2", 32'(pass_s[0]), 32'd1);

    // Abort during CHECK of vector 1, which would otherwise score a fail.
    fault_s[0] = 1;
    start_edge(0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pre_a", 32'(a_s[0]), 32'd0);
    chk("t5_pre_b", 32'(b_s[0]), 32'd1);
    abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    $display("run5 abort: busy=%0d done=%0d fc=%0d", busy_s[0], done_s[0], fc_s[0]);
    chk("t5_busy", 32'(busy_s[0]), 32'd0);
    chk("t5_done", 32'(done_s[0]), 32'd0);
    chk("t5_fc", 32'(fc_s[0]), 32'd0);
    chk("t5_a", 32'(a_s[0]), 32'd0);
    chk("t5_b", 32'(b_s[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("t5_idle", 32'(busy_s[0]), 32'd0);

    // Asynchronous reset during APPLY of vector 2.
    fault_s[0] = 0;
    start_edge(0);
    repeat (4) @(posedge clk);
    #1 chk("t6_pre_a", 32'(a_s[0]), 32'd1);
    #1 resetN = 1'b0;
    #1;
    $display("run6 reset: busy=%0d a=%0d b=%0d", busy_s[0], a_s[0], b_s[0]);
    chk("t6_busy", 32'(busy_s[0]), 32'd0);
    chk("t6_a", 32'(a_s[0]), 32'd0);
    chk("t6_b", 32'(b_s[0]), 32'd0);
    chk("t6_fc", 32'(fc_s[0]), 32'd0);
    @(negedge clk); #1 resetN = 1'b1;
    start_edge(0);
    wait_done(0, el);
    $display("run7 after reset: elapsed=%0d pass=%0d", el, pass_s[0]);
    chk("t6_lat", 32'(el), 32'd8);
    chk("t6_pass", 32'(pass_s[0]), 32'd1);

    // 16-bit gate, SETTLE=3, bit 7 inverted on vector {1,0}.
    fault_s[1] = 2;
    start_edge(1);
    wait_done(1, el);
    $display("run8 w16: elapsed=%0d pass=%0d fc=%0d ff=%0d", el, pass_s[1], fc_s[1], ff_s[1]);
    chk("t3_lat", 32'(el), 32'd16);
    chk("t3_pass", 32'(pass_s[1]), 32'd0);
    chk("t3_fc", 32'(fc_s[1]), 32'd1);
    chk("t3_ff", 32'(ff_s[1]), 32'd2);

    // Start and abort together in DONE: start wins.
    fault_s[1] = 0;
    abort_s[1] = 1'b1;
    start_edge(1);
    abort_s[1] = 1'b0;
    chk("t7_busy", 32'(busy_s[1]), 32'd1);
    wait_done(1, el);
    $display("run9 start+abort: elapsed=%0d pass=%0d", el, pass_s[1]);
    chk("t7_lat", 32'(el), 32'd16);
    chk("t7_pass", 32'(pass_s[1]), 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
